// File: rtl/esr_clock_pkg.sv
// esr_clock_pkg: shared types, constants and helpers for the esr_clock time-of-day core.
package esr_clock_pkg;

  // Packed BCD time, {hh, mm, ss}, two BCD digits per field.
  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } clk_state_e;

  localparam bcd_time_t BCD_MIDNIGHT = 24'h00_00_00;

  // Per-digit maximum values before wrapping.
  localparam logic [3:0] SEC_U_MAX   = 4'd9;
  localparam logic [3:0] SEC_T_MAX   = 4'd5;
  localparam logic [3:0] MIN_U_MAX   = 4'd9;
  localparam logic [3:0] MIN_T_MAX   = 4'd5;
  localparam logic [3:0] HR_U_MAX_LO = 4'd9;  // hours 00..19
  localparam logic [3:0] HR_U_MAX_HI = 4'd3;  // hours 20..23
  localparam logic [3:0] HR_T_MAX    = 4'd2;

  // True when every digit is decimal and each field is in range.
  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic ok;
    ok = 1'b1;
    if (t.ss[3:0] > 4'd9) ok = 1'b0;
    if (t.mm[3:0] > 4'd9) ok = 1'b0;
    if (t.hh[3:0] > 4'd9) ok = 1'b0;
    if (t.ss > 8'h59)     ok = 1'b0;
    if (t.mm > 8'h59)     ok = 1'b0;
    if (t.hh > 8'h23)     ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/esr_clock_bcd_digit.sv
// esr_clock_bcd_digit: one BCD digit with increment, programmable wrap value,
// carry out and synchronous load. Load has priority over increment.
module esr_clock_bcd_digit (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic [3:0] max_val,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic [3:0] value_nxt,
  output logic       carry
);

  logic [3:0] value_r;

  assign value = value_r;
  assign carry = inc && (value_r == max_val);

  // Next digit value: load, then wrapping increment, else hold.
  always_comb begin
    value_nxt = value_r;
    if (load) begin
      value_nxt = load_val;
    end else if (inc) begin
      if (carry) value_nxt = 4'd0;
      else       value_nxt = value_r + 4'd1;
    end else begin
      value_nxt = value_r;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) value_r <= 4'd0;
    else       value_r <= value_nxt;
  end

endmodule

// File: rtl/esr_clock_core.sv
// esr_clock_core: BCD hh:mm:ss time-of-day counter with prescaler, validated
// set-time load and optional alarm (enabled with macro ESR_CLOCK_ALARM_EN).
module esr_clock_core
  import esr_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        load_valid,
  input  logic [23:0] load_time,
  output logic        load_err,
  output logic [23:0] time_out,
  output logic        sec_tick,
  output logic        day_wrap,
  output logic        running,
  input  logic        alarm_en,
  input  logic [23:0] alarm_time,
  input  logic        alarm_clr,
  output logic        alarm_pend
);

  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICKS_PER_SEC - 1);

  clk_state_e     state_r, state_nxt_s;
  logic [CNT_W-1:0] presc_r;
  logic           cnt_en_s, tick_s, inc_s;
  logic           load_ok_s, load_bad_s;
  logic           load_err_r, sec_tick_r, day_wrap_r;
  bcd_time_t      load_bcd_s, cur_time_s, new_time_s;
  logic [3:0]     hr_u_max_s;
  logic [5:0]     carry_s;

  assign load_bcd_s = load_time;
  assign load_ok_s  = load_valid && bcd_time_valid(load_bcd_s);
  assign load_bad_s = load_valid && !bcd_time_valid(load_bcd_s);

  // Next FSM state follows the run control.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      STOP:    if (run) state_nxt_s = RUN;  else state_nxt_s = STOP;
      RUN:     if (!run) state_nxt_s = STOP; else state_nxt_s = RUN;
      default: state_nxt_s = STOP;
    endcase
  end

  // The prescaler advances on every edge that leaves the FSM in RUN, so the
  // edge entering RUN already counts and a paused second resumes where it stopped.
  assign cnt_en_s = (state_nxt_s == RUN);
  assign tick_s   = cnt_en_s && (presc_r == PRE_MAX);
  assign inc_s    = tick_s && !load_ok_s;  // a valid load discards the tick

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= STOP;
    else       state_r <= state_nxt_s;
  end

  // Prescaler: cleared by a valid load or a tick, held while stopped.
  always_ff @(posedge clock) begin
    if (reset)                presc_r <= '0;
    else if (load_ok_s)       presc_r <= '0;
    else if (tick_s)          presc_r <= '0;
    else if (cnt_en_s)        presc_r <= presc_r + 1'b1;
    else                      presc_r <= presc_r;
  end

  // Hour units wrap at 3 once the tens digit is 2 (23 -> 00).
  assign hr_u_max_s = (cur_time_s.hh[7:4] == 4'd2) ? HR_U_MAX_HI : HR_U_MAX_LO;

  esr_clock_bcd_digit u_sec_u (
    .clock(clock), .reset(reset), .inc(inc_s), .max_val(SEC_U_MAX),
    .load(load_ok_s), .load_val(load_bcd_s.ss[3:0]),
    .value(cur_time_s.ss[3:0]), .value_nxt(new_time_s.ss[3:0]), .carry(carry_s[0])
  );
  esr_clock_bcd_digit u_sec_t (
    .clock(clock), .reset(reset), .inc(carry_s[0]), .max_val(SEC_T_MAX),
    .load(load_ok_s), .load_val(load_bcd_s.ss[7:4]),
    .value(cur_time_s.ss[7:4]), .value_nxt(new_time_s.ss[7:4]), .carry(carry_s[1])
  );
  esr_clock_bcd_digit u_min_u (
    .clock(clock), .reset(reset), .inc(carry_s[1]), .max_val(MIN_U_MAX),
    .load(load_ok_s), .load_val(load_bcd_s.mm[3:0]),
    .value(cur_time_s.mm[3:0]), .value_nxt(new_time_s.mm[3:0]), .carry(carry_s[2])
  );
  esr_clock_bcd_digit u_min_t (
    .clock(clock), .reset(reset), .inc(carry_s[2]), .max_val(MIN_T_MAX),
    .load(load_ok_s), .load_val(load_bcd_s.mm[7:4]),
    .value(cur_time_s.mm[7:4]), .value_nxt(new_time_s.mm[7:4]), .carry(carry_s[3])
  );
  esr_clock_bcd_digit u_hr_u (
    .clock(clock), .reset(reset), .inc(carry_s[3]), .max_val(hr_u_max_s),
    .load(load_ok_s), .load_val(load_bcd_s.hh[3:0]),
    .value(cur_time_s.hh[3:0]), .value_nxt(new_time_s.hh[3:0]), .carry(carry_s[4])
  );
  esr_clock_bcd_digit u_hr_t (
    .clock(clock), .reset(reset), .inc(carry_s[4]), .max_val(HR_T_MAX),
    .load(load_ok_s), .load_val(load_bcd_s.hh[7:4]),
    .value(cur_time_s.hh[7:4]), .value_nxt(new_time_s.hh[7:4]), .carry(carry_s[5])
  );

  // Status pulses, registered so they align with the updated time.
  always_ff @(posedge clock) begin
    if (reset) begin
      sec_tick_r <= 1'b0;
      day_wrap_r <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      sec_tick_r <= inc_s;
      day_wrap_r <= carry_s[5];
      load_err_r <= load_bad_s;
    end
  end

  assign time_out = cur_time_s;
  assign sec_tick = sec_tick_r;
  assign day_wrap = day_wrap_r;
  assign load_err = load_err_r;
  assign running  = (state_r == RUN);

`ifdef ESR_CLOCK_ALARM_EN
  logic alarm_pend_r;

  // Sticky alarm: set on a tick whose new time matches, set beats clear.
  always_ff @(posedge clock) begin
    if (reset)                                             alarm_pend_r <= 1'b0;
    else if (inc_s && alarm_en && (new_time_s == alarm_time)) alarm_pend_r <= 1'b1;
    else if (alarm_clr)                                    alarm_pend_r <= 1'b0;
    else                                                   alarm_pend_r <= alarm_pend_r;
  end

  assign alarm_pend = alarm_pend_r;
`else
  logic unused_alarm_s;
  logic [23:0] unused_new_time_s;
  assign unused_alarm_s    = alarm_en ^ alarm_clr ^ (^alarm_time);
  assign unused_new_time_s = new_time_s;
  assign alarm_pend        = 1'b0;
`endif

endmodule

// File: tb/tb_esr_clock_core.sv
// tb_esr_clock_core: directed self-checking bench for esr_clock_core, TICKS_PER_SEC = 4.
module tb_esr_clock_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        load_valid;
  logic [23:0] load_time;
  logic        load_err;
  logic [23:0] time_out;
  logic        sec_tick;
  logic        day_wrap;
  logic        running;
  logic        alarm_en;
  logic [23:0] alarm_time;
  logic        alarm_clr;
  logic        alarm_pend;

  int vectors = 0;
  int miscompares = 0;
  int ticks;
  logic [23:0] bad_vec [4];

  esr_clock_core #(.TICKS_PER_SEC(4)) dut (
    .clock(clock), .reset(reset), .run(run),
    .load_valid(load_valid), .load_time(load_time), .load_err(load_err),
    .time_out(time_out), .sec_tick(sec_tick), .day_wrap(day_wrap), .running(running),
    .alarm_en(alarm_en), .alarm_time(alarm_time), .alarm_clr(alarm_clr),
    .alarm_pend(alarm_pend)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; load_valid = 1'b0; load_time = 24'h0;
    alarm_en = 1'b0; alarm_time = 24'h0; alarm_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("reset_time", time_out, 24'h000000);
    chk("reset_running", {23'd0, running}, 24'd0);
    chk("reset_tick", {23'd0, sec_tick}, 24'd0);
    chk("reset_wrap", {23'd0, day_wrap}, 24'd0);
    chk("reset_err", {23'd0, load_err}, 24'd0);
    chk("reset_alarm", {23'd0, alarm_pend}, 24'd0);

    // Count for 12 cycles: ticks at cycles 4, 8, 12.
    run = 1'b1; ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (sec_tick) ticks++;
      if (i == 1) chk("running_set", {23'd0, running}, 24'd1);
      if (i == 3) chk("pre_tick_time", time_out, 24'h000000);
      if (i == 4) chk("first_tick_time", time_out, 24'h000001);
      if (i == 4) chk("first_tick_pulse", {23'd0, sec_tick}, 24'd1);
    end
    chk("time_after_12", time_out, 24'h000003);
    chk("tick_count_12", ticks, 24'd3);

    // Load 23:59:58 and roll over midnight.
    load_valid = 1'b1; load_time = 24'h235958;
    step();
    load_valid = 1'b0;
    chk("load_2359", time_out, 24'h235958);
    chk("load_no_tick", {23'd0, sec_tick}, 24'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) chk("t_235959", time_out, 24'h235959);
      if (i == 4) chk("no_wrap_yet", {23'd0, day_wrap}, 24'd0);
      if (i == 7) chk("wrap_hold", time_out, 24'h235959);
    end
    chk("midnight", time_out, 24'h000000);
    chk("day_wrap", {23'd0, day_wrap}, 24'd1);
    chk("wrap_tick", {23'd0, sec_tick}, 24'd1);
    run = 1'b0;
    step();
    chk("wrap_pulse_end", {23'd0, day_wrap}, 24'd0);
    chk("stopped", {23'd0, running}, 24'd0);

    // Invalid loads while stopped.
    bad_vec[0] = 24'h240000; bad_vec[1] = 24'h126000;
    bad_vec[2] = 24'h120A00; bad_vec[3] = 24'h12005F;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_time = bad_vec[i];
      step();
      load_valid = 1'b0;
      chk("bad_load_err", {23'd0, load_err}, 24'd1);
      chk("bad_load_time", time_out, 24'h000000);
      step();
      chk("bad_load_err_end", {23'd0, load_err}, 24'd0);
    end

    // Pause mid-second: 2 run cycles, 10 stopped, 2 run.
    run = 1'b1; step(); step();
    run = 1'b0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sec_tick) ticks++;
    end
    chk("paused_ticks", ticks, 24'd0);
    chk("paused_time", time_out, 24'h000000);
    run = 1'b1;
    step();
    chk("resume_3rd", time_out, 24'h000000);
    step();
    chk("resume_4th", time_out, 24'h000001);
    chk("resume_tick", {23'd0, sec_tick}, 24'd1);

    // Valid load on the tick edge wins.
    step(); step(); step();
    load_valid = 1'b1; load_time = 24'h100000;
    step();
    load_valid = 1'b0;
    chk("load_on_tick", time_out, 24'h100000);
    chk("load_on_tick_pulse", {23'd0, sec_tick}, 24'd0);
    step(); step(); step();
    chk("after_load_hold", time_out, 24'h100000);
    step();
    chk("after_load_tick", time_out, 24'h100001);
    chk("after_load_pulse", {23'd0, sec_tick}, 24'd1);

    // Invalid load on a tick edge does not block the tick.
    step(); step(); step();
    load_valid = 1'b1; load_time = 24'h126000;
    step();
    load_valid = 1'b0;
    chk("bad_on_tick_time", time_out, 24'h100002);
    chk("bad_on_tick_pulse", {23'd0, sec_tick}, 24'd1);
    chk("bad_on_tick_err", {23'd0, load_err}, 24'd1);

    // Alarm behaviour.
    run = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    alarm_time = 24'h000002; alarm_en = 1'b1; run = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
`ifdef ESR_CLOCK_ALARM_EN
      if (i == 4) chk("alarm_not_yet", {23'd0, alarm_pend}, 24'd0);
      if (i == 8) chk("alarm_set", {23'd0, alarm_pend}, 24'd1);
`endif
      if (i == 8) alarm_time = 24'h000003;
    end
    alarm_clr = 1'b1;
    step();
    chk("alarm_clr_tick_time", time_out, 24'h000003);
`ifdef ESR_CLOCK_ALARM_EN
    chk("alarm_set_beats_clr", {23'd0, alarm_pend}, 24'd1);
`endif
    step();
    alarm_clr = 1'b0;
    chk("alarm_cleared", {23'd0, alarm_pend}, 24'd0);
    run = 1'b0;
    load_valid = 1'b1; load_time = 24'h000003;
    step();
    load_valid = 1'b0;
    chk("alarm_load_match", {23'd0, alarm_pend}, 24'd0);

    // Reset mid-operation overrides a load.
    run = 1'b1; step(); step();
    reset = 1'b1; load_valid = 1'b1; load_time = 24'h121212;
    step();
    reset = 1'b0; load_valid = 1'b0; run = 1'b0;
    chk("reset_over_load", time_out, 24'h000000);
    chk("reset_running_mid", {23'd0, running}, 24'd0);
    step(); step(); step(); step();
    chk("reset_presc_cleared", time_out, 24'h000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
